// File: rtl/data_axi_bridge.sv
// Data-side sram_like to single-beat AXI bridge with one transaction outstanding.
// Optional build macro DATA_BRIDGE_RLATCH_EN registers read data and delays the read data_ok by one cycle.
module data_axi_bridge #(
    parameter int ID_W    = 4,
    parameter int DATA_ID = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            data_req,
    input  logic            data_wr,
    input  logic [1:0]      data_size,
    input  logic [31:0]     data_addr,
    input  logic [31:0]     data_wdata,
    output logic [31:0]     data_rdata,
    output logic            data_addr_ok,
    output logic            data_data_ok,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [1:0]      awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready,
    output logic [2:0]      fsm_state
);

    // Handshake rule on every AXI channel: a beat transfers on a rising edge where valid & ready
    // are both high; the bridge holds each valid until that edge and never retracts it.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RD_DONE = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q;
    logic        wr_q, aw_done, w_done;
    logic        aw_hs, w_hs, wr_both;

    assign aw_hs   = (state == WR_REQ) && !aw_done && awready;
    assign w_hs    = (state == WR_REQ) && !w_done && wready;
    assign wr_both = (state == WR_REQ) && (aw_done || aw_hs) && (w_done || w_hs);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (data_addr_ok) begin
                addr_q  <= data_addr;
                size_q  <= data_size;
                wdata_q <= data_wdata;
                wr_q    <= data_wr;
            end
            // Both flags clear together once the write request phase is complete.
            if (wr_both) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (rready && rvalid) rdata_q <= rdata;
        end
    end

    always_comb begin
        state_nxt    = state;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (state)
            IDLE: begin
                data_addr_ok = data_req;
                if (data_req) state_nxt = data_wr ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
`ifdef DATA_BRIDGE_RLATCH_EN
                    state_nxt = RD_DONE;
`else
                    data_data_ok = 1'b1;
                    state_nxt    = IDLE;
`endif
                end
            end
            RD_DONE: begin
                data_data_ok = 1'b1;
                state_nxt    = IDLE;
            end
            WR_REQ: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if (wr_both) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_data_ok = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DATA_BRIDGE_RLATCH_EN
    assign data_rdata = rdata_q;
`else
    assign data_rdata = (state == RD_DATA && rvalid) ? rdata : rdata_q;
`endif

    always_comb begin
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    assign arid    = ID_W'(DATA_ID);
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign awid    = ID_W'(DATA_ID);
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wid     = ID_W'(DATA_ID);
    assign wdata   = wdata_q;
    assign wlast   = 1'b1;

    assign fsm_state = state;

    // Response codes and IDs are deliberately dropped; the latched direction is kept for debug.
    logic unused_ok;
    assign unused_ok = &{1'b0, wr_q, rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_data_axi_bridge.sv
// Self-checking bench for data_axi_bridge: directed scenarios plus randomized transactions
// checked against a transaction-level model of the bridge's observable behaviour.
module tb_data_axi_bridge;
    localparam int ID_W = 4;
    localparam logic [2:0] IDLE_ENC = 3'd0;
`ifdef DATA_BRIDGE_RLATCH_EN
    localparam int RD_LAT = 3;
`else
    localparam int RD_LAT = 2;
`endif

    logic clk = 1'b0, resetn;
    logic data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0] data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [ID_W-1:0] arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, arprot, awsize, awprot, fsm_state;
    logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
    logic [3:0] arcache, awcache, wstrb;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic wlast, wvalid, wready, bvalid, bready;

    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    data_axi_bridge #(.ID_W(ID_W), .DATA_ID(1)) dut (
        .clk(clk), .resetn(resetn),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .fsm_state(fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte lanes touched by an access of 2**size bytes (reserved size = 4 bytes).
    function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [1:0] a);
        int n, off;
        n   = (size >= 2'd2) ? 4 : (1 << size);
        off = int'(a) & ~(n - 1);
        return 4'(((1 << n) - 1) << off);
    endfunction

    task automatic slaves_idle();
        arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
        rdata = 32'h0; rid = '0; rresp = 2'b00; rlast = 1'b1; bid = '0; bresp = 2'b00;
    endtask

    // One transaction, cycle by cycle: drives the request, plays the AXI slave with the given
    // ready/response delays, and checks every bridge output against the expected behaviour.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int d_a, input int d_w, input int d_r, input logic keep_req,
                           output int w_beats, output int ok_cyc);
        bit a_done = 0, w_done = 0, resp_done = 0, finished = 0;
        int t_addr = -1, t_rhs = -1, c = 0;
        w_beats = 0;
        ok_cyc  = -1;
        data_wr = wr; data_addr = addr; data_size = size; data_wdata = wd;
        while (!finished) begin
            bit ph_done, exp_arv, exp_awv, exp_wv, exp_rr, exp_br, exp_ok;
            @(negedge clk);
            if (c > 40) begin
                checks++;
                errors++;
                $display("FAIL txn_timeout observed=%0d cycles expected<=40", c);
                data_req = 1'b0;
                slaves_idle();
                break;
            end
            ph_done  = a_done && (w_done || !wr);
            data_req = (c == 0) || keep_req;
            arready  = !wr && !a_done && (c >= 1 + d_a);
            awready  = wr && !a_done && (c >= 1 + d_a);
            wready   = wr && !w_done && (c >= 1 + d_w);
            rvalid   = !wr && ph_done && !resp_done && (c >= t_addr + 1 + d_r);
            bvalid   = wr && ph_done && !resp_done && (c >= t_addr + 1 + d_r);
            rdata    = rvalid ? rd : $urandom;
            if (rvalid) exp_q.push_back(rd);
            #1;
            exp_arv = !wr && (c >= 1) && !a_done;
            exp_awv = wr && (c >= 1) && !a_done;
            exp_wv  = wr && (c >= 1) && !w_done;
            exp_rr  = !wr && ph_done && !resp_done;
            exp_br  = wr && ph_done && !resp_done;
`ifdef DATA_BRIDGE_RLATCH_EN
            exp_ok  = wr ? bvalid : (t_rhs >= 0 && c == t_rhs + 1);
`else
            exp_ok  = wr ? bvalid : rvalid;
`endif
            if (c == 0) chk("rdata_hold", data_rdata, last_rd);
            chk("addr_ok", data_addr_ok, c == 0);
            chk("arvalid", arvalid, exp_arv);
            chk("awvalid", awvalid, exp_awv);
            chk("wvalid", wvalid, exp_wv);
            chk("rready", rready, exp_rr);
            chk("bready", bready, exp_br);
            chk("data_ok", data_data_ok, exp_ok);
            if (c == 1) chk("fixed_attr", {arlen, arburst, arlock, arcache, arprot, awlen,
                            awburst, awlock, awcache, awprot, wlast},
                            {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1});
            if (exp_arv) begin
                chk("araddr", araddr, addr);
                chk("arsize", arsize, {1'b0, size});
                chk("arid", arid, 1);
            end
            if (exp_awv) begin
                chk("awaddr", awaddr, addr);
                chk("awsize", awsize, {1'b0, size});
            end
            if (wvalid && wready) begin
                w_beats++;
                chk("wdata", wdata, wd);
                chk("wstrb", wstrb, model_strb(size, addr[1:0]));
            end
            if (exp_ok && !wr) begin
                if (exp_q.size() == 0) chk("rd_queue_empty", 1, 0);
                else chk("data_rdata", data_rdata, exp_q.pop_front());
            end
            if ((exp_arv && arready) || (exp_awv && awready)) a_done = 1;
            if (exp_wv && wready) w_done = 1;
            if (!ph_done && a_done && (w_done || !wr)) t_addr = c;
            if (rvalid) begin resp_done = 1; t_rhs = c; last_rd = rd; end
            if (bvalid) resp_done = 1;
            if (exp_ok) begin finished = 1; ok_cyc = c; end
            c++;
        end
    endtask

    initial begin
        int wb, oc, n;
        logic wr;
        logic [1:0] sz;
        logic [31:0] a;

        resetn = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        data_addr = 32'h0; data_wdata = 32'h0; last_rd = 32'h0;
        slaves_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", {arvalid, awvalid, wvalid, rready, bready, data_addr_ok, data_data_ok}, 0);
        chk("reset_rdata", data_rdata, 32'h0);
        chk("reset_state", fsm_state, IDLE_ENC);
        chk("reset_latched", {araddr, wdata, wstrb}, {32'h0, 32'h0, 4'b0001});
        @(negedge clk);
        resetn = 1'b1;

        // Word read, best case.
        run_txn(1'b0, 32'h0000_1000, 2'd2, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, wb, oc);
        chk("rd_latency", oc, RD_LAT);

        // Byte store to the top lane, best case.
        run_txn(1'b1, 32'h0000_2003, 2'd0, 32'hAB00_0000, 32'h0, 0, 0, 0, 1'b0, wb, oc);
        chk("wr_latency", oc, 2);
        chk("wr_beats_byte", wb, 1);

        // W accepted three cycles before AW.
        run_txn(1'b1, 32'h0000_2100, 2'd2, 32'h1234_5678, 32'h0, 3, 0, 0, 1'b0, wb, oc);
        chk("wr_beats_split", wb, 1);
        chk("wr_split_latency", oc, 5);

        // Request held high during a slow read, then the next one must go in on the first IDLE cycle.
        run_txn(1'b0, 32'h0000_3004, 2'd2, 32'h0, 32'hCAFE_F00D, 0, 0, 5, 1'b1, wb, oc);
        run_txn(1'b0, 32'h0000_3006, 2'd1, 32'h0, 32'h0000_5A5A, 0, 0, 0, 1'b0, wb, oc);
        chk("rd_after_hold_latency", oc, RD_LAT);

        // Reset while waiting for read data.
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_3000; data_size = 2'd2;
        slaves_idle();
        @(negedge clk);
        data_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        #1;
        chk("pre_reset_rready", rready, 1);
        resetn = 1'b0;
        #1;
        chk("midrst_ctrl", {arvalid, awvalid, wvalid, rready, bready, data_addr_ok, data_data_ok}, 0);
        chk("midrst_state", fsm_state, IDLE_ENC);
        chk("midrst_rdata", data_rdata, 32'h0);
        last_rd = 32'h0;
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post_reset_state", fsm_state, IDLE_ENC);
        run_txn(1'b0, 32'h0000_4002, 2'd1, 32'h0, 32'h0000_BEEF, 0, 0, 0, 1'b0, wb, oc);

        // Randomized mix of reads and writes with random slave delays.
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            n  = (sz >= 2'd2) ? 4 : (1 << sz);
            a  = $urandom & ~(32'(n) - 32'd1);
            run_txn(wr, a, sz, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), ($urandom_range(0, 3) == 0), wb, oc);
            if (wr) chk("rand_w_beats", wb, 1);
        end

        @(negedge clk);
        data_req = 1'b0;
        slaves_idle();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_axi_bridge.md
# data_axi_bridge

- Converts the data-side sram_like requests from the memory-access stage into single-beat AXI transactions on the data port, and returns read data and completion back to that stage.
- Sits directly downstream of the memory-access stage, between its `data_*` interface and the AXI interconnect or arbiter.
- At most one transaction is outstanding at any time.
- Fixed AXI attributes: `len=0`, `burst=INCR`, `lock/cache/prot=0`.

## Interface

Parameters
- `ID_W`, default 4: AXI ID width.
- `DATA_ID`, default 1: constant driven on `arid`/`awid`.

Ports
- `clk` in 1: clock; all state updates on rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `data_req` in 1: request valid (sram_like).
- `data_wr` in 1: 1 = write, 0 = read.
- `data_size` in 2: 0 = byte, 1 = halfword, 2 = word; 3 is reserved and treated as word.
- `data_addr` in 32: physical address.
- `data_wdata` in 32: lane-aligned store data.
- `data_rdata` out 32: read data, valid while `data_data_ok`.
- `data_addr_ok` out 1: request accepted this cycle.
- `data_data_ok` out 1: one-cycle pulse marking read data valid or write complete.
- AR channel: `arid` out `ID_W`, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arlock` out 2, `arcache` out 4, `arprot` out 3, `arvalid` out 1, `arready` in 1.
- R channel: `rid` in `ID_W`, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- AW channel: `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awlock`, `awcache`, `awprot` with the same widths as AR; `awvalid` out 1, `awready` in 1.
- W channel: `wid` out `ID_W`, `wdata` out 32, `wstrb` out 4, `wlast` out 1 (tied 1), `wvalid` out 1, `wready` in 1.
- B channel: `bid` in `ID_W`, `bresp` in 2, `bvalid` in 1, `bready` out 1.

## Operation

State machine: `IDLE`, `RD_ADDR`, `RD_DATA`, `WR_REQ`, `WR_RESP`.

- **Acceptance**
  - `data_addr_ok = (state==IDLE) & data_req` (combinational).
  - On that edge, latch `addr`, `size`, `wdata`, `wr` into internal registers and move to `RD_ADDR` if `wr=0`, else `WR_REQ`.
- **RD_ADDR**
  - `arvalid=1`; `araddr`/`arsize={1'b0,size}` come from the latched values.
  - On `arready`, go to `RD_DATA`.
- **RD_DATA**
  - `rready=1`.
  - On `rvalid`: pulse `data_data_ok`, present `rdata` on `data_rdata`, return to `IDLE`.
- **WR_REQ**
  - `awvalid` and `wvalid` are asserted together.
  - Flags `aw_done`/`w_done` record each handshake independently; each valid drops after its own handshake.
  - When both flags are set (including the same cycle), go to `WR_RESP` and clear the flags.
- **WR_RESP**
  - `bready=1`.
  - On `bvalid`: pulse `data_data_ok`, return to `IDLE`.
- **wstrb from latched size and addr[1:0]**
  - Byte: `4'b0001 << addr[1:0]`.
  - Halfword: `addr[1] ? 4'b1100 : 4'b0011`.
  - Word or reserved: `4'b1111`.
- `wdata` passes through unchanged; the upstream stage has already placed the data in its lane.
- `rresp`, `bresp` and `rid`/`bid` are ignored; errors are not reported upstream.
- Misaligned requests never arrive, because the upstream stage suppresses `data_req` on address errors. The bridge does not check alignment.
- `data_rdata` holds its last value between reads.

## Timing

- **Reset values:** state `IDLE`; all `*valid`, `rready`, `bready`, `data_addr_ok`, `data_data_ok` = 0; `data_rdata` = 0; latched registers = 0.
- **Read, best case**
  - Request accepted in cycle 0.
  - `arvalid` asserted in cycle 1; `arready` arrives in cycle 1.
  - `rvalid` arrives in cycle 2, and `data_data_ok` pulses in cycle 2.
  - `IDLE` in cycle 3.
- **Write, best case:** accepted in cycle 0; AW and W handshake in cycle 1; B in cycle 2; `data_data_ok` in cycle 2.
- The next request can be accepted in the first `IDLE` cycle after completion. Back-to-back throughput is therefore one transaction per 3 cycles minimum.
- `data_req` held while not in `IDLE`: not accepted; no `addr_ok`.
- AXI valids stay high until their handshake, independent of `data_req`; the bridge never retracts a valid.
- `resetn` low mid-transaction: immediate return to `IDLE` with all valids cleared. The interconnect is reset on the same signal.

## Configuration

- `DATA_BRIDGE_RLATCH_EN` defined:
  - `rdata` is captured into a register on the `rvalid & rready` edge.
  - `data_data_ok` for reads pulses the following cycle from an extra internal state `RD_DONE`, then the FSM returns to `IDLE`.
  - Read latency is +1 cycle; this removes the combinational `rdata`→`data_rdata` path.
- Undefined: `data_rdata = rdata` combinationally while in `RD_DATA`, and `data_data_ok` pulses in the `rvalid` cycle.
- Writes are identical in both builds.

## Test plan

- **Word read:** req read addr 0x00001000, size 2; `arready` immediate; `rvalid` in the next cycle with 0xDEADBEEF.
  - `araddr` = 0x00001000, `arsize` = 3'b010.
  - `data_data_ok` for one cycle with `data_rdata` = 0xDEADBEEF, in cycle 2 (cycle 3 with macro).
- **Byte store** addr 0x00002003, wdata 0xAB000000, size 0: `wstrb` = 4'b1000, `awsize` = 3'b000, `wdata` = 0xAB000000; `data_data_ok` in the `bvalid` cycle.
- **Independent AW/W:** `wready` arrives 3 cycles before `awready`.
  - `wvalid` drops after its handshake.
  - Exactly one W beat is issued.
  - `WR_RESP` is entered only after `awready`.
- **Request held while busy:** `data_req` held high during a pending read with `rvalid` delayed 5 cycles.
  - `data_addr_ok` stays 0 until `IDLE`.
  - The second request is accepted on the first `IDLE` cycle.
- **Reset mid-read:** `resetn` asserted low while in `RD_DATA`.
  - All valids and ready outputs go to 0 immediately.
  - After release, state is `IDLE` and a new halfword read at 0x...2 gives `arsize` = 3'b001.
